// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared constants and helpers for the data-side memory access
//               unit. It holds the load/store op codes, the bus size codes, the
//               FSM state encoding, and the alignment and size helpers.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

   // Load/store op codes carried on mem_op_i
   localparam logic [2:0] c_OP_LB  = 3'd0;
   localparam logic [2:0] c_OP_LBU = 3'd1;
   localparam logic [2:0] c_OP_LH  = 3'd2;
   localparam logic [2:0] c_OP_LHU = 3'd3;
   localparam logic [2:0] c_OP_LW  = 3'd4;
   localparam logic [2:0] c_OP_SB  = 3'd5;
   localparam logic [2:0] c_OP_SH  = 3'd6;
   localparam logic [2:0] c_OP_SW  = 3'd7;

   // Bus transfer size codes carried on data_size
   localparam logic [1:0] c_SIZE_BYTE = 2'd0;
   localparam logic [1:0] c_SIZE_HALF = 2'd1;
   localparam logic [1:0] c_SIZE_WORD = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   function automatic logic isStoreOp(input logic [2:0] op);
      return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
   endfunction

   // Halfword ops need an even address; word ops need a word-aligned address.
   function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] offset);
      logic halfOp;
      logic wordOp;
      halfOp = (op == c_OP_LH) || (op == c_OP_LHU) || (op == c_OP_SH);
      wordOp = (op == c_OP_LW) || (op == c_OP_SW);
      return (halfOp && offset[0]) || (wordOp && (offset != 2'b00));
   endfunction

   function automatic logic [1:0] opSize(input logic [2:0] op);
      case (op)
         c_OP_LB, c_OP_LBU, c_OP_SB: return c_SIZE_BYTE;
         c_OP_LH, c_OP_LHU, c_OP_SH: return c_SIZE_HALF;
         default:                    return c_SIZE_WORD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ldext.sv
`default_nettype none
// ============================================================================
// Module      : mem_ldext
// Description : Combinational load formatter. It selects a byte or halfword
//               from the raw bus word by byte offset, then sign- or
//               zero-extends it according to the load op.
// Ports       : op     in  3   load op code
//               offset in  2   byte offset of the access (address bits 1:0)
//               raw    in  32  raw word returned by the bus
//               ext    out 32  extended load result
// Revision    : 1.0  initial release
// ============================================================================
module mem_ldext
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (offset)
         2'd0:    w_byte = raw[7:0];
         2'd1:    w_byte = raw[15:8];
         2'd2:    w_byte = raw[23:16];
         default: w_byte = raw[31:24];
      endcase
      w_half = offset[1] ? raw[31:16] : raw[15:0];

      case (op)
         c_OP_LB:  ext = {{24{w_byte[7]}}, w_byte};
         c_OP_LBU: ext = {24'h000000, w_byte};
         c_OP_LH:  ext = {{16{w_half[15]}}, w_half};
         c_OP_LHU: ext = {16'h0000, w_half};
         default:  ext = raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Data-side memory access unit. It turns a MEM-stage load/store
//               into a two-phase bus transaction (address handshake, then data
//               handshake) and checks alignment. It stalls the pipeline until
//               the access completes and returns the extended load data.
// Ports       : clk, rst (async, active low)
//               mem_en_i, mem_op_i, addr_i, wdata_i, flush_i   pipeline side
//               rdata_o, stall_o, adel_o, ades_o, badvaddr_o    pipeline side
//               data_req/wr/size/addr/wdata/wstrb               bus request
//               data_addr_ok, data_data_ok, data_rdata          bus response
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en_i,
   input  logic [2:0]  mem_op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        flush_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic [31:0] badvaddr_o,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   state_e      r_state;
   state_e      w_nextState;
   logic        r_addrPending;
   logic        w_nextPending;
   logic [31:0] r_reqAddr;
   logic [31:0] r_reqWdata;
   logic [3:0]  r_reqWstrb;
   logic [1:0]  r_reqSize;
   logic        r_reqWr;
   logic [2:0]  r_reqOp;
   logic [31:0] r_rdata;

   logic        w_isStore;
   logic        w_misaligned;
   logic        w_validAccess;
   logic        w_issue;
   logic        w_req;
   logic        w_capture;
   logic [31:0] w_fmtWdata;
   logic [3:0]  w_fmtWstrb;
   logic [1:0]  w_fmtSize;
   logic [31:0] w_ldExt;

   assign w_isStore     = isStoreOp(mem_op_i);
   assign w_misaligned  = isMisaligned(mem_op_i, addr_i[1:0]);
   assign w_validAccess = mem_en_i && !w_misaligned;

   // Store formatting: replicate narrow data across the word so the bus can
   // pick any lane, and let the strobes say which lanes are written.
   always_comb begin
      w_fmtSize  = opSize(mem_op_i);
      w_fmtWdata = 32'h0000_0000;
      w_fmtWstrb = 4'b0000;
      case (mem_op_i)
         c_OP_SB: begin
            w_fmtWdata = {4{wdata_i[7:0]}};
            w_fmtWstrb = 4'b0001 << addr_i[1:0];
         end
         c_OP_SH: begin
            w_fmtWdata = {2{wdata_i[15:0]}};
            w_fmtWstrb = addr_i[1] ? 4'b1100 : 4'b0011;
         end
         c_OP_SW: begin
            w_fmtWdata = wdata_i;
            w_fmtWstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   // Next-state and handshake control. r_addrPending tracks "address phase
   // not yet accepted" so DRAIN knows whether it must keep requesting.
   always_comb begin
      w_nextState   = r_state;
      w_nextPending = 1'b0;
      w_issue       = 1'b0;
      w_req         = 1'b0;
      w_capture     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_validAccess && !flush_i) begin
               w_issue       = 1'b1;
               w_req         = 1'b1;
               w_nextPending = !data_addr_ok;
               w_nextState   = data_addr_ok ? S_WAIT : S_REQ;
            end
         end
         S_REQ: begin
            // Once raised, the request stays up until accepted, even across a flush.
            w_req         = 1'b1;
            w_nextPending = !data_addr_ok;
            if (flush_i)
               w_nextState = S_DRAIN;
            else if (data_addr_ok)
               w_nextState = S_WAIT;
         end
         S_WAIT: begin
            if (data_data_ok) begin
               w_capture   = !flush_i && !r_reqWr;
               w_nextState = flush_i ? S_IDLE : S_DONE;
            end else if (flush_i) begin
               w_nextState = S_DRAIN;
            end
         end
         S_DONE: w_nextState = S_IDLE;
         S_DRAIN: begin
            w_req         = r_addrPending;
            w_nextPending = r_addrPending && !data_addr_ok;
            if (!r_addrPending && data_data_ok)
               w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   mem_ldext u_ldext (
      .op     (r_reqOp),
      .offset (r_reqAddr[1:0]),
      .raw    (data_rdata),
      .ext    (w_ldExt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_addrPending <= 1'b0;
         r_reqAddr     <= 32'h0000_0000;
         r_reqWdata    <= 32'h0000_0000;
         r_reqWstrb    <= 4'b0000;
         r_reqSize     <= 2'b00;
         r_reqWr       <= 1'b0;
         r_reqOp       <= 3'd0;
         r_rdata       <= 32'h0000_0000;
      end else begin
         r_state       <= w_nextState;
         r_addrPending <= w_nextPending;
         if (w_issue) begin
            r_reqAddr  <= addr_i;
            r_reqWdata <= w_fmtWdata;
            r_reqWstrb <= w_fmtWstrb;
            r_reqSize  <= w_fmtSize;
            r_reqWr    <= w_isStore;
            r_reqOp    <= mem_op_i;
         end
         if (w_capture)
            r_rdata <= w_ldExt;
      end
   end

   // In the issue cycle the request is driven straight from the inputs; after
   // that it comes from the latched copy so input changes cannot disturb it.
   assign data_req   = w_req;
   assign data_wr    = w_req && (w_issue ? w_isStore : r_reqWr);
   assign data_size  = w_req ? (w_issue ? w_fmtSize  : r_reqSize)  : 2'b00;
   assign data_addr  = w_req ? (w_issue ? addr_i     : r_reqAddr)  : 32'h0000_0000;
   assign data_wdata = w_req ? (w_issue ? w_fmtWdata : r_reqWdata) : 32'h0000_0000;
   assign data_wstrb = w_req ? (w_issue ? w_fmtWstrb : r_reqWstrb) : 4'b0000;

   assign stall_o    = w_validAccess && !flush_i && (r_state != S_DONE);
   assign adel_o     = mem_en_i && w_misaligned && !w_isStore;
   assign ades_o     = mem_en_i && w_misaligned && w_isStore;
   assign badvaddr_o = addr_i;
   assign rdata_o    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Stimulus pushes the
//               expected bus requests, results and exceptions into queues; a
//               monitor pops and compares whenever the DUT presents them. A
//               small bus responder answers with programmable delays.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en_i = 1'b0;
   logic [2:0]  mem_op_i = 3'd0;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] wdata_i = 32'h0;
   logic        flush_i = 1'b0;
   logic [31:0] rdata_o;
   logic        stall_o, adel_o, ades_o;
   logic [31:0] badvaddr_o;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = 32'h0;

   typedef struct { logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
   typedef struct { logic [31:0] rdata; int stalls; } res_t;
   typedef struct { logic adel; logic ades; logic [31:0] bad; } exc_t;

   req_t        reqQ[$];
   res_t        resQ[$];
   exc_t        excQ[$];
   logic [31:0] busRdQ[$];

   int checks = 0;
   int errors = 0;

   // bus responder state
   int          addrDelay = 0;
   int          dataDelay = 1;
   int          reqWait = 0;
   int          dataLeft = 0;
   bit          dataPending = 1'b0;
   bit          busKill = 1'b0;
   bit          sReq, sAok;
   logic [31:0] curRd = 32'h0;
   int          stallCnt = 0;

   assign data_addr_ok = data_req && (reqWait >= addrDelay);

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .mem_en_i(mem_en_i), .mem_op_i(mem_op_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .rdata_o(rdata_o), .stall_o(stall_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic failNote(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Bus responder: address accept after addrDelay request cycles, data
   // returned dataDelay cycles after acceptance.
   initial begin
      forever begin
         @(negedge clk);
         sReq = data_req;
         sAok = data_addr_ok;
         @(posedge clk);
         #1;
         data_data_ok = 1'b0;
         if (busKill) begin
            dataPending = 1'b0;
            reqWait     = 0;
            busKill     = 1'b0;
         end else begin
            if (sReq && sAok) begin
               reqWait     = 0;
               dataPending = 1'b1;
               dataLeft    = dataDelay;
               curRd       = (busRdQ.size() > 0) ? busRdQ.pop_front() : 32'h0;
            end else if (sReq) begin
               reqWait++;
            end
            if (dataPending) begin
               if (dataLeft <= 1) begin
                  data_data_ok = 1'b1;
                  data_rdata   = curRd;
                  dataPending  = 1'b0;
               end else begin
                  dataLeft--;
               end
            end
         end
      end
   end

   // Monitor: compares requests, completions and exceptions as they appear.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst || flush_i) begin
            stallCnt = 0;
         end else if (mem_en_i && stall_o) begin
            stallCnt++;
         end else if (mem_en_i && stallCnt > 0) begin
            if (resQ.size() == 0) failNote("unexpected completion");
            else begin
               res_t r;
               r = resQ.pop_front();
               chk("result.rdata", rdata_o, r.rdata);
               chk("result.stalls", stallCnt, r.stalls);
            end
            stallCnt = 0;
         end
         if (data_req) begin
            if (reqQ.size() == 0) failNote("unexpected bus request");
            else begin
               chk("req.wr", {31'h0, data_wr}, {31'h0, reqQ[0].wr});
               chk("req.size", {30'h0, data_size}, {30'h0, reqQ[0].size});
               chk("req.addr", data_addr, reqQ[0].addr);
               chk("req.wdata", data_wdata, reqQ[0].wdata);
               chk("req.wstrb", {28'h0, data_wstrb}, {28'h0, reqQ[0].wstrb});
               if (data_addr_ok) void'(reqQ.pop_front());
            end
         end
         if (adel_o || ades_o) begin
            if (excQ.size() == 0) failNote("unexpected exception");
            else begin
               exc_t e;
               e = excQ.pop_front();
               chk("exc.adel", {31'h0, adel_o}, {31'h0, e.adel});
               chk("exc.ades", {31'h0, ades_o}, {31'h0, e.ades});
               chk("exc.badvaddr", badvaddr_o, e.bad);
               chk("exc.noreq", {31'h0, data_req}, 32'h0);
               chk("exc.nostall", {31'h0, stall_o}, 32'h0);
            end
         end
      end
   end

   task automatic waitDone(input int chgAt, input logic [31:0] chgAddr, input logic [31:0] chgWdata);
      int n = 0;
      forever begin
         @(negedge clk);
         if (!stall_o) break;
         n++;
         if (n > 60) begin
            failNote("timeout waiting for stall release");
            break;
         end
         if (n == chgAt) begin
            @(posedge clk);
            #1;
            addr_i  = chgAddr;
            wdata_i = chgWdata;
         end
      end
      @(posedge clk);
      #1;
      mem_en_i = 1'b0;
   endtask

   task automatic doAccess(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input int aDly, input int dDly, input logic [31:0] busRd,
                           input logic eWr, input logic [1:0] eSize, input logic [31:0] eWdata,
                           input logic [3:0] eWstrb, input logic [31:0] eRdata, input int eStalls,
                           input int chgAt, input logic [31:0] chgAddr, input logic [31:0] chgWdata);
      req_t q;
      res_t r;
      q.wr = eWr; q.size = eSize; q.addr = addr; q.wdata = eWdata; q.wstrb = eWstrb;
      r.rdata = eRdata; r.stalls = eStalls;
      reqQ.push_back(q);
      resQ.push_back(r);
      busRdQ.push_back(busRd);
      @(posedge clk);
      #1;
      addrDelay = aDly;
      dataDelay = dDly;
      mem_op_i  = op;
      addr_i    = addr;
      wdata_i   = wd;
      mem_en_i  = 1'b1;
      waitDone(chgAt, chgAddr, chgWdata);
   endtask

   task automatic doMisaligned(input logic [2:0] op, input logic [31:0] addr, input logic eAdel, input logic eAdes);
      exc_t e;
      e.adel = eAdel; e.ades = eAdes; e.bad = addr;
      excQ.push_back(e);
      @(posedge clk);
      #1;
      mem_op_i = op;
      addr_i   = addr;
      wdata_i  = 32'h0;
      mem_en_i = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      mem_en_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_t q;
      res_t r;
      int n;
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.rdata", rdata_o, 32'h0);
      chk("reset.req", {31'h0, data_req}, 32'h0);
      chk("reset.stall", {31'h0, stall_o}, 32'h0);
      chk("reset.exc", {30'h0, adel_o, ades_o}, 32'h0);
      chk("reset.wstrb", {28'h0, data_wstrb}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // LB sign-extend from the top byte; 3 stall cycles
      doAccess(c_OP_LB, 32'h1000_0003, 32'h0, 0, 2, 32'h80FF_FF7F,
               1'b0, 2'd0, 32'h0, 4'b0000, 32'hFFFF_FF80, 3, 0, 32'h0, 32'h0);
      // SH upper half; result register must keep the previous load
      doAccess(c_OP_SH, 32'h0000_0102, 32'h1234_ABCD, 0, 1, 32'hFFFF_FFFF,
               1'b1, 2'd1, 32'hABCD_ABCD, 4'b1100, 32'hFFFF_FF80, 2, 0, 32'h0, 32'h0);
      // misaligned accesses
      doMisaligned(c_OP_LW, 32'h0000_0006, 1'b1, 1'b0);
      doMisaligned(c_OP_SW, 32'h0000_0001, 1'b0, 1'b1);
      doMisaligned(c_OP_LH, 32'h0000_0001, 1'b1, 1'b0);
      // LHU with a 4-cycle address stall; inputs change mid-request
      doAccess(c_OP_LHU, 32'h0000_0002, 32'h0, 4, 1, 32'h8001_0000,
               1'b0, 2'd1, 32'h0, 4'b0000, 32'h0000_8001, 6, 2, 32'h0000_0006, 32'h5555_5555);
      // SB lane 1
      doAccess(c_OP_SB, 32'h0000_0101, 32'h0000_00A5, 1, 1, 32'h0,
               1'b1, 2'd0, 32'hA5A5_A5A5, 4'b0010, 32'h0000_8001, 3, 0, 32'h0, 32'h0);
      // LH sign-extend upper half
      doAccess(c_OP_LH, 32'h0000_0002, 32'h0, 0, 1, 32'h8001_1234,
               1'b0, 2'd1, 32'h0, 4'b0000, 32'hFFFF_8001, 2, 0, 32'h0, 32'h0);
      // LBU zero-extend byte 1
      doAccess(c_OP_LBU, 32'h0000_0001, 32'h0, 0, 1, 32'h0000_F000,
               1'b0, 2'd0, 32'h0, 4'b0000, 32'h0000_00F0, 2, 0, 32'h0, 32'h0);
      // SW full word
      doAccess(c_OP_SW, 32'h0000_0008, 32'hCAFE_BABE, 0, 1, 32'h0,
               1'b1, 2'd2, 32'hCAFE_BABE, 4'b1111, 32'h0000_00F0, 2, 0, 32'h0, 32'h0);

      // Flush in WAIT, then a new LW that must wait out the old transaction
      q.wr = 1'b0; q.size = 2'd2; q.addr = 32'h0000_0100; q.wdata = 32'h0; q.wstrb = 4'b0000;
      reqQ.push_back(q);
      busRdQ.push_back(32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      addrDelay = 0;
      dataDelay = 4;
      mem_op_i = c_OP_LW; addr_i = 32'h0000_0100; wdata_i = 32'h0; mem_en_i = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush.stall", {31'h0, stall_o}, 32'h0);
      chk("flush.req", {31'h0, data_req}, 32'h0);
      q.addr = 32'h0000_0200;
      reqQ.push_back(q);
      busRdQ.push_back(32'h0BAD_F00D);
      r.rdata = 32'h0BAD_F00D; r.stalls = 4;
      resQ.push_back(r);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      addr_i = 32'h0000_0200;
      dataDelay = 1;
      @(negedge clk);
      chk("drain.stall", {31'h0, stall_o}, 32'h1);
      chk("drain.rdata_hold", rdata_o, 32'h0000_00F0);
      n = 1;
      waitDone(0, 32'h0, 32'h0);

      // Reset pulsed while waiting for data
      q.addr = 32'h0000_0300;
      reqQ.push_back(q);
      busRdQ.push_back(32'hCAFE_F00D);
      @(posedge clk);
      #1;
      addrDelay = 0;
      dataDelay = 5;
      mem_op_i = c_OP_LW; addr_i = 32'h0000_0300; mem_en_i = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_en_i = 1'b0;
      busKill = 1'b1;
      @(negedge clk);
      chk("midreset.rdata", rdata_o, 32'h0);
      chk("midreset.req", {31'h0, data_req}, 32'h0);
      chk("midreset.stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      // a fresh LW after reset must see a clean IDLE start
      doAccess(c_OP_LW, 32'h0000_0400, 32'h0, 0, 1, 32'h1234_5678,
               1'b0, 2'd2, 32'h0, 4'b0000, 32'h1234_5678, 2, 0, 32'h0, 32'h0);

      repeat (3) @(posedge clk);
      chk("reqQ.empty", reqQ.size(), 32'd0);
      chk("resQ.empty", resQ.size(), 32'd0);
      chk("excQ.empty", excQ.size(), 32'd0);
      chk("busRdQ.empty", busRdQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Data-side memory access unit sitting between the MEM stage of the pipelined MIPS datapath and the data SRAM-like bus. It converts the MEM-stage load/store into a two-phase bus transaction (address handshake, then data handshake) with correct size and byte strobes, checks alignment, and stalls the pipeline until the access completes. It returns sign- or zero-extended load data in the form the datapath consumes as `readdataM`.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk  in  1  pipeline clock; all state changes on the rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `mem_en_i  in  1  MEM-stage instruction is a load or store`
- `mem_op_i  in  3  access op: LB, LBU, LH, LHU, LW, SB, SH, SW (codes in defines.vh)`
- `addr_i  in  32  effective address (aluoutM)`
- `wdata_i  in  32  store data (writedataM)`
- `flush_i  in  1  exception flush of MEM stage`
- `rdata_o  out  32  extended load result (readdataM)`
- `stall_o  out  1  hold the pipeline (drives the hazard unit)`
- `adel_o  out  1  misaligned load`
- `ades_o  out  1  misaligned store`
- `badvaddr_o  out  32  faulting address; equals addr_i`
- `data_req  out  1  bus request`
- `data_wr  out  1  1 = write`
- `data_size  out  2  0 byte, 1 half, 2 word`
- `data_addr  out  32  byte address`
- `data_wdata  out  32  replicated store data`
- `data_wstrb  out  4  byte strobes; 0 for reads`
- `data_addr_ok  in  1  address accepted`
- `data_data_ok  in  1  data returned or write done`
- `data_rdata  in  32  read data, valid with data_ok`

## Operation
- Alignment check: LH, LHU and SH need `addr_i[0]==0`; LW and SW need `addr_i[1:0]==0`.
- A misaligned access behaves as follows:
  - no bus request is issued;
  - `adel_o` or `ades_o` asserts combinationally while `mem_en_i` is high;
  - `stall_o` stays 0.
- Store formatting:
  - SB: `data_wdata` = byte replicated four times; `data_wstrb` = one-hot at `addr[1:0]`.
  - SH: `data_wdata` = halfword replicated; `data_wstrb` = 4'b0011 or 4'b1100 by `addr[1]`.
  - SW: `data_wstrb` = 4'b1111.
- Load formatting:
  - Byte or half is selected from `data_rdata` using the latched `addr[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- FSM states:
  - IDLE: when there is a valid aligned access and `flush_i==0`, drive `data_req`; on `data_addr_ok` go to WAIT, otherwise go to REQ.
  - REQ: hold `data_req`, address, size, wdata and wstrb stable until `data_addr_ok`, then go to WAIT.
  - WAIT: on `data_data_ok`, capture the extended data into the result register and go to DONE.
  - DONE: `stall_o`=0 for exactly one cycle so the pipeline advances, then go to IDLE.
  - DRAIN: the bus transaction was killed by flush. Wait for `data_addr_ok` (if still pending) and `data_data_ok`, discard the data, then go to IDLE.
- `stall_o` = (valid aligned access) AND state ∉ {DONE} AND NOT `flush_i`. In DRAIN, `stall_o` is 1 whenever a new valid access is presented.
- Flush in IDLE: no request is issued.
- Flush in REQ or WAIT: go to DRAIN. A handshake already begun on the bus is never abandoned.
- Request fields are registered at issue, so changes on `addr_i` or `wdata_i` during REQ or WAIT have no effect.

## Timing
- Reset: state IDLE; every output is 0, including the result register behind `rdata_o`.
- Best case for a load:
  - cycle 0: `data_req` and `data_addr_ok`;
  - cycle 1: `data_data_ok`;
  - cycle 2: DONE, `rdata_o` valid, `stall_o`=0.
- So the minimum stall is 2 cycles. `data_data_ok` is never sampled in the same cycle as `data_addr_ok` for the same request.
- `rdata_o` is registered and holds its value until the next capture.
- Back-to-back accesses: a new request is issued no earlier than the cycle after DONE.
- Reset asserted mid-transaction: immediate return to IDLE with outputs cleared. Bus-side recovery is the bus's responsibility.

## Structure
- Op codes and data-size codes live in `defines.vh`, alongside the other shared constants.
- One natural sub-module: `mem_ldext`, a combinational byte/half select and extend block. Inputs are op, offset and raw data; output is the extended result.
- The FSM, alignment check and store formatting stay in the top module.

## Test plan
- LB at 0x1000_0003, bus returns 0x80FF_FF7F with 1-cycle addr_ok and 2-cycle data_ok → `rdata_o`=0xFFFF_FF80; `stall_o` high for exactly 3 cycles.
- SH at 0x0000_0102 with `wdata_i`=0x1234_ABCD → `data_wdata`=0xABCD_ABCD, `data_wstrb`=4'b1100, `data_size`=1, `data_wr`=1.
- LW at 0x0000_0006 → `adel_o`=1, `badvaddr_o`=0x0000_0006, `data_req`=0, `stall_o`=0. SW at 0x0000_0001 → `ades_o`=1.
- LHU at 0x0000_0002 with `data_addr_ok` delayed 4 cycles → request fields stay stable through REQ; `data_rdata`=0x8001_0000 yields `rdata_o`=0x0000_8001.
- `flush_i` in WAIT, followed by a new LW → no stall on the flush cycle, then the new LW stalls in DRAIN until the old `data_data_ok`; old data is never seen on `rdata_o`.
- `rst` pulsed low in WAIT → all outputs 0 and state IDLE on the next edge.
